mmu_xlate_arbiter: RTL and testbench
====================================

MMU_XLATE_ARBITER -- requirements
Module: mmu_xlate_arbiter

Interface
REQ-001 The block SHALL have parameter REQ_W, default 43, meaning virtual request payload width.
REQ-002 The block SHALL have parameter RSP_W, default 33, meaning physical response payload width.
REQ-003 The block SHALL have parameter MAX_OUT, default 4 (power of two, 2..16), meaning the maximum number of outstanding translations.
REQ-004 The block SHALL have port s_axi_clk  in  1  as the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port s_aresetn  in  1  as the reset: asynchronous assert, active-low.
REQ-006 The block SHALL have ports rd_req_tdata  in  REQ_W, rd_req_tvalid  in  1, rd_req_tready  out  1, forming the read-side virtual request stream.
REQ-007 The block SHALL have ports wr_req_tdata  in  REQ_W, wr_req_tvalid  in  1, wr_req_tready  out  1, forming the write-side virtual request stream.
REQ-008 The block SHALL have ports xl_req_tdata  out  REQ_W+1, xl_req_tvalid  out  1, xl_req_tready  in  1, forming the request stream to the shared translation engine; the MSB is the direction (1 = write).
REQ-009 The block SHALL have ports xl_rsp_tdata  in  RSP_W, xl_rsp_tvalid  in  1, xl_rsp_tready  out  1, carrying in-order responses from the translation engine.
REQ-010 The block SHALL have ports rd_rsp_tdata  out  RSP_W, rd_rsp_tvalid  out  1, rd_rsp_tready  in  1, forming the read-side physical response stream.
REQ-011 The block SHALL have ports wr_rsp_tdata  out  RSP_W, wr_rsp_tvalid  out  1, wr_rsp_tready  in  1, forming the write-side physical response stream.
REQ-012 The block SHALL have port outstanding  out  clog2(MAX_OUT)+1, giving the current count of issued but unanswered translations.
REQ-013 The block SHALL have port orphan_err  out  1, a sticky flag set when a response arrives with no outstanding request.

Function
REQ-014 The block SHALL hold a one-entry registered output stage; xl_req_tvalid/xl_req_tdata SHALL be driven only from this register.
REQ-015 The stage SHALL be loadable in any cycle where it is empty, or full with xl_req_tready=1, and outstanding < MAX_OUT.
REQ-016 When loadable and exactly one of rd_req_tvalid/wr_req_tvalid is 1, that stream SHALL be granted.
REQ-017 When loadable and both are valid, the stream not granted last SHALL be granted (round-robin); last_grant resets to WR, so RD wins the first contention.
REQ-018 rd_req_tready/wr_req_tready SHALL be 1 only for the granted stream in a loadable cycle; at most one SHALL be high per cycle.
REQ-019 On a grant, the stage SHALL capture {dir, tdata} and xl_req_tvalid SHALL be 1 in the next cycle (1-cycle latency), held stable until xl_req_tready=1.
REQ-020 On a grant, dir SHALL be pushed into a MAX_OUT-deep in-order tag FIFO.
REQ-021 The count SHALL be +1 on grant, -1 on response handshake, and unchanged when both occur in the same cycle.
REQ-022 With the tag FIFO non-empty, the response SHALL be routed combinationally by the head tag: head=0 makes rd_rsp_tvalid=xl_rsp_tvalid and xl_rsp_tready=rd_rsp_tready; head=1 does the same on the wr side.
REQ-023 rd_rsp_tdata and wr_rsp_tdata SHALL both equal xl_rsp_tdata; the non-selected tvalid SHALL be 0.
REQ-024 The tag SHALL be popped on a response handshake; a pop and a push in the same cycle SHALL both take effect.
REQ-025 With the tag FIFO empty, xl_rsp_tready SHALL be 1, both rsp tvalid SHALL be 0, and xl_rsp_tvalid=1 SHALL set orphan_err and drop the beat.
REQ-026 orphan_err SHALL be cleared only by reset.
REQ-027 outstanding = MAX_OUT SHALL block new grants; a response handshake in that cycle SHALL NOT unblock the same cycle (grant uses the registered count).
REQ-028 Tag FIFO pointers SHALL wrap modulo MAX_OUT.

Reset
REQ-029 While s_aresetn=0, the block SHALL force xl_req_tvalid=0, rd/wr_req_tready=0, outstanding=0, orphan_err=0, tag FIFO empty, last_grant=WR, and rd/wr_rsp_tvalid=0.
REQ-030 Reset mid-operation SHALL discard the staged request and all tags; responses arriving after reset release SHALL count as orphans.

Verification
REQ-031 Single RD request 0x123 with xl_req_tready=1: xl_req_tdata={0,0x123} one cycle later; response 0x1AB goes to rd_rsp only; outstanding returns 0 -> 1 -> 0.
REQ-032 Both RD and WR valid continuously, xl_req_tready=1: grants alternate RD, WR, RD, WR; the MSB pattern is 0,1,0,1.
REQ-033 MAX_OUT=4 with no responses: exactly 4 grants, then both req_tready stay 0 and outstanding=4; one response re-enables a grant on the next cycle.
REQ-034 Issue order R,W,W,R, then responses A,B,C,D: A->rd, B->wr, C->wr, D->rd; wr_rsp_tready=0 during B stalls xl_rsp_tready with no loss.
REQ-035 Response beat with outstanding=0: beat dropped, orphan_err=1 and held until reset.
REQ-036 Assert s_aresetn=0 with 3 outstanding and a staged request: all outputs reach reset values immediately (asynchronously); after release, the first grant goes to RD.

Source files
------------

// File: rtl/mmu_xlate_arbiter.sv
// mmu_xlate_arbiter: shares one in-order translation engine between a read and
// a write virtual-request stream. Requests are arbitrated round-robin into a
// one-entry output register. A direction tag FIFO steers each in-order
// response back to the stream that issued it. Responses arriving with nothing
// outstanding are dropped, and they set a sticky orphan flag.
module mmu_xlate_arbiter #(
  parameter int REQ_W   = 43,
  parameter int RSP_W   = 33,
  parameter int MAX_OUT = 4
) (
  input  logic                       s_axi_clk,
  input  logic                       s_aresetn,
  input  logic [REQ_W-1:0]           rd_req_tdata,
  input  logic                       rd_req_tvalid,
  output logic                       rd_req_tready,
  input  logic [REQ_W-1:0]           wr_req_tdata,
  input  logic                       wr_req_tvalid,
  output logic                       wr_req_tready,
  output logic [REQ_W:0]             xl_req_tdata,
  output logic                       xl_req_tvalid,
  input  logic                       xl_req_tready,
  input  logic [RSP_W-1:0]           xl_rsp_tdata,
  input  logic                       xl_rsp_tvalid,
  output logic                       xl_rsp_tready,
  output logic [RSP_W-1:0]           rd_rsp_tdata,
  output logic                       rd_rsp_tvalid,
  input  logic                       rd_rsp_tready,
  output logic [RSP_W-1:0]           wr_rsp_tdata,
  output logic                       wr_rsp_tvalid,
  input  logic                       wr_rsp_tready,
  output logic [$clog2(MAX_OUT):0]   outstanding,
  output logic                       orphan_err
);

  localparam int CW = $clog2(MAX_OUT);
  localparam logic [CW:0] MaxCnt = (CW+1)'(MAX_OUT);
  localparam logic DirRd = 1'b0;
  localparam logic DirWr = 1'b1;

  logic             r_stageValid;
  logic [REQ_W:0]   r_stageData;
  logic             r_lastGrant;
  logic [CW:0]      r_count;
  logic             r_orphan;
  logic             r_tags [MAX_OUT];
  logic [CW-1:0]    r_wrPtr;
  logic [CW-1:0]    r_rdPtr;

  logic             w_loadable;
  logic             w_grantRd;
  logic             w_grantWr;
  logic             w_push;
  logic             w_tagEmpty;
  logic             w_headTag;
  logic             w_rspHs;
  logic             w_orphanBeat;

  // Arbitration uses the registered count, so a response in a full cycle cannot free a slot until the next cycle.
  always_comb begin
    w_loadable = s_aresetn && (!r_stageValid || xl_req_tready) && (r_count < MaxCnt);
    w_grantRd  = w_loadable && rd_req_tvalid && (!wr_req_tvalid || (r_lastGrant == DirWr));
    w_grantWr  = w_loadable && wr_req_tvalid && (!rd_req_tvalid || (r_lastGrant == DirRd));
    w_push     = w_grantRd || w_grantWr;
  end

  assign rd_req_tready = w_grantRd;
  assign wr_req_tready = w_grantWr;
  assign xl_req_tvalid = r_stageValid;
  assign xl_req_tdata  = r_stageData;

  // Steer the response by the oldest tag; with no tags the beat is sunk and flagged.
  always_comb begin
    w_tagEmpty    = (r_count == '0);
    w_headTag     = r_tags[r_rdPtr];
    rd_rsp_tvalid = !w_tagEmpty && (w_headTag == DirRd) && xl_rsp_tvalid;
    wr_rsp_tvalid = !w_tagEmpty && (w_headTag == DirWr) && xl_rsp_tvalid;
    if (w_tagEmpty) begin
      xl_rsp_tready = 1'b1;
    end else if (w_headTag == DirWr) begin
      xl_rsp_tready = wr_rsp_tready;
    end else begin
      xl_rsp_tready = rd_rsp_tready;
    end
    w_rspHs      = !w_tagEmpty && xl_rsp_tvalid && xl_rsp_tready;
    w_orphanBeat = w_tagEmpty && xl_rsp_tvalid;
  end

  assign rd_rsp_tdata = xl_rsp_tdata;
  assign wr_rsp_tdata = xl_rsp_tdata;
  assign outstanding  = r_count;
  assign orphan_err   = r_orphan;

  // Output stage: load on grant, otherwise empty once the engine accepts.
  always_ff @(posedge s_axi_clk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      r_stageValid <= 1'b0;
      r_stageData  <= '0;
    end else if (w_push) begin
      r_stageValid <= 1'b1;
      r_stageData  <= w_grantWr ? {DirWr, wr_req_tdata} : {DirRd, rd_req_tdata};
    end else if (xl_req_tready) begin
      r_stageValid <= 1'b0;
    end
  end

  // Remember the last winner so contention alternates; WR after reset lets RD win first.
  always_ff @(posedge s_axi_clk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      r_lastGrant <= DirWr;
    end else if (w_push) begin
      r_lastGrant <= w_grantWr;
    end
  end

  // Outstanding count doubles as tag FIFO occupancy.
  always_ff @(posedge s_axi_clk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_rspHs})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Tag FIFO: push direction on grant, pop on response handshake; pointers wrap naturally.
  always_ff @(posedge s_axi_clk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      for (int i = 0; i < MAX_OUT; i++) begin
        r_tags[i] <= 1'b0;
      end
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) begin
        r_tags[r_wrPtr] <= w_grantWr;
        r_wrPtr         <= r_wrPtr + 1'b1;
      end
      if (w_rspHs) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
    end
  end

  // Sticky orphan flag, cleared only by reset.
  always_ff @(posedge s_axi_clk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      r_orphan <= 1'b0;
    end else if (w_orphanBeat) begin
      r_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mmu_xlate_arbiter.sv
// Scoreboard bench for mmu_xlate_arbiter: directed stimulus pushes expected
// beats into queues, and a negedge monitor pops them and compares them on
// every output handshake.
module tb_mmu_xlate_arbiter;
  localparam int REQ_W   = 43;
  localparam int RSP_W   = 33;
  localparam int MAX_OUT = 4;

  logic                     s_axi_clk = 1'b0;
  logic                     s_aresetn = 1'b1;
  logic [REQ_W-1:0]         rd_req_tdata;
  logic                     rd_req_tvalid;
  logic                     rd_req_tready;
  logic [REQ_W-1:0]         wr_req_tdata;
  logic                     wr_req_tvalid;
  logic                     wr_req_tready;
  logic [REQ_W:0]           xl_req_tdata;
  logic                     xl_req_tvalid;
  logic                     xl_req_tready;
  logic [RSP_W-1:0]         xl_rsp_tdata;
  logic                     xl_rsp_tvalid;
  logic                     xl_rsp_tready;
  logic [RSP_W-1:0]         rd_rsp_tdata;
  logic                     rd_rsp_tvalid;
  logic                     rd_rsp_tready;
  logic [RSP_W-1:0]         wr_rsp_tdata;
  logic                     wr_rsp_tvalid;
  logic                     wr_rsp_tready;
  logic [$clog2(MAX_OUT):0] outstanding;
  logic                     orphan_err;

  int total = 0;
  int bad   = 0;

  logic [REQ_W:0]   expXl [$];
  logic [RSP_W-1:0] expRd [$];
  logic [RSP_W-1:0] expWr [$];
  logic [REQ_W:0]   monXl;
  logic [RSP_W-1:0] monRsp;

  mmu_xlate_arbiter #(.REQ_W(REQ_W), .RSP_W(RSP_W), .MAX_OUT(MAX_OUT)) dut (
    .s_axi_clk(s_axi_clk), .s_aresetn(s_aresetn),
    .rd_req_tdata(rd_req_tdata), .rd_req_tvalid(rd_req_tvalid), .rd_req_tready(rd_req_tready),
    .wr_req_tdata(wr_req_tdata), .wr_req_tvalid(wr_req_tvalid), .wr_req_tready(wr_req_tready),
    .xl_req_tdata(xl_req_tdata), .xl_req_tvalid(xl_req_tvalid), .xl_req_tready(xl_req_tready),
    .xl_rsp_tdata(xl_rsp_tdata), .xl_rsp_tvalid(xl_rsp_tvalid), .xl_rsp_tready(xl_rsp_tready),
    .rd_rsp_tdata(rd_rsp_tdata), .rd_rsp_tvalid(rd_rsp_tvalid), .rd_rsp_tready(rd_rsp_tready),
    .wr_rsp_tdata(wr_rsp_tdata), .wr_rsp_tvalid(wr_rsp_tvalid), .wr_rsp_tready(wr_rsp_tready),
    .outstanding(outstanding), .orphan_err(orphan_err)
  );

  always #5 s_axi_clk = ~s_axi_clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic cycle();
    @(posedge s_axi_clk);
    #1;
  endtask

  task automatic flushQueues();
    expXl.delete();
    expRd.delete();
    expWr.delete();
  endtask

  // Drive one request on the chosen stream and hold it until granted.
  task automatic applyStimulus(input logic dir, input logic [REQ_W-1:0] data);
    int   n  = 0;
    logic ok = 1'b0;
    expXl.push_back({dir, data});
    if (dir) begin
      wr_req_tdata = data; wr_req_tvalid = 1'b1;
    end else begin
      rd_req_tdata = data; rd_req_tvalid = 1'b1;
    end
    while (!ok && n < 50) begin
      @(negedge s_axi_clk);
      if ((dir ? wr_req_tready : rd_req_tready) === 1'b1) ok = 1'b1;
      else n++;
      cycle();
    end
    if (dir) wr_req_tvalid = 1'b0;
    else     rd_req_tvalid = 1'b0;
    checkOutput("req_grant_wait", {63'd0, ok}, 64'd1);
  endtask

  // Present one response beat and hold it until the engine side handshakes.
  task automatic sendRsp(input logic [RSP_W-1:0] data, input logic dir);
    int   n  = 0;
    logic ok = 1'b0;
    if (dir) expWr.push_back(data);
    else     expRd.push_back(data);
    xl_rsp_tdata  = data;
    xl_rsp_tvalid = 1'b1;
    while (!ok && n < 50) begin
      @(negedge s_axi_clk);
      if (xl_rsp_tready === 1'b1) ok = 1'b1;
      else n++;
      cycle();
    end
    xl_rsp_tvalid = 1'b0;
    checkOutput("rsp_accept_wait", {63'd0, ok}, 64'd1);
  endtask

  task automatic doReset();
    s_aresetn = 1'b0;
    flushQueues();
    cycle();
    cycle();
    s_aresetn = 1'b1;
    cycle();
  endtask

  // Monitor: compare every output handshake against the scoreboard queues.
  always @(negedge s_axi_clk) begin
    if (s_aresetn) begin
      checkOutput("req_ready_onehot", {63'd0, rd_req_tready & wr_req_tready}, 64'd0);
      if (xl_req_tvalid && xl_req_tready) begin
        checkOutput("xl_req_expected_pending", {63'd0, expXl.size() != 0}, 64'd1);
        if (expXl.size() != 0) begin
          monXl = expXl.pop_front();
          checkOutput("xl_req_tdata", 64'(xl_req_tdata), 64'(monXl));
        end
      end
      if (rd_rsp_tvalid && rd_rsp_tready) begin
        checkOutput("rd_rsp_expected_pending", {63'd0, expRd.size() != 0}, 64'd1);
        if (expRd.size() != 0) begin
          monRsp = expRd.pop_front();
          checkOutput("rd_rsp_tdata", 64'(rd_rsp_tdata), 64'(monRsp));
        end
      end
      if (wr_rsp_tvalid && wr_rsp_tready) begin
        checkOutput("wr_rsp_expected_pending", {63'd0, expWr.size() != 0}, 64'd1);
        if (expWr.size() != 0) begin
          monRsp = expWr.pop_front();
          checkOutput("wr_rsp_tdata", 64'(wr_rsp_tdata), 64'(monRsp));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rd_req_tdata = '0; rd_req_tvalid = 1'b1;
    wr_req_tdata = '0; wr_req_tvalid = 1'b0;
    xl_req_tready = 1'b1;
    xl_rsp_tdata = '0; xl_rsp_tvalid = 1'b0;
    rd_rsp_tready = 1'b1; wr_rsp_tready = 1'b1;

    // Reset state, with a valid read pending to show tready is held low.
    #1 s_aresetn = 1'b0;
    cycle();
    cycle();
    checkOutput("rst_xl_req_tvalid", {63'd0, xl_req_tvalid}, 64'd0);
    checkOutput("rst_rd_req_tready", {63'd0, rd_req_tready}, 64'd0);
    checkOutput("rst_wr_req_tready", {63'd0, wr_req_tready}, 64'd0);
    checkOutput("rst_outstanding", 64'(outstanding), 64'd0);
    checkOutput("rst_orphan_err", {63'd0, orphan_err}, 64'd0);
    checkOutput("rst_rd_rsp_tvalid", {63'd0, rd_rsp_tvalid}, 64'd0);
    checkOutput("rst_wr_rsp_tvalid", {63'd0, wr_rsp_tvalid}, 64'd0);
    rd_req_tvalid = 1'b0;
    s_aresetn = 1'b1;
    cycle();

    // Single read: one-cycle latency, response routed to read side.
    applyStimulus(1'b0, 43'h123);
    checkOutput("single_latency_valid", {63'd0, xl_req_tvalid}, 64'd1);
    checkOutput("single_outstanding_1", 64'(outstanding), 64'd1);
    sendRsp(33'h1AB, 1'b0);
    checkOutput("single_outstanding_0", 64'(outstanding), 64'd0);

    // Engine backpressure: staged beat held stable and further grants blocked.
    xl_req_tready = 1'b0;
    applyStimulus(1'b0, 43'h055);
    checkOutput("bp_valid", {63'd0, xl_req_tvalid}, 64'd1);
    checkOutput("bp_data_0", 64'(xl_req_tdata), 64'h055);
    wr_req_tdata = 43'h066; wr_req_tvalid = 1'b1;
    @(negedge s_axi_clk);
    checkOutput("bp_wr_blocked", {63'd0, wr_req_tready}, 64'd0);
    cycle();
    checkOutput("bp_data_1", 64'(xl_req_tdata), 64'h055);
    wr_req_tvalid = 1'b0;
    xl_req_tready = 1'b1;
    cycle();
    checkOutput("bp_drained", {63'd0, xl_req_tvalid}, 64'd0);
    sendRsp(33'h155, 1'b0);

    // Round robin under contention, then the outstanding limit.
    doReset();
    rd_req_tdata = 43'h100; rd_req_tvalid = 1'b1;
    wr_req_tdata = 43'h200; wr_req_tvalid = 1'b1;
    expXl.push_back({1'b0, 43'h100});
    expXl.push_back({1'b1, 43'h200});
    expXl.push_back({1'b0, 43'h101});
    expXl.push_back({1'b1, 43'h201});
    for (int i = 0; i < 4; i++) begin
      @(negedge s_axi_clk);
      checkOutput("rr_rd_ready", {63'd0, rd_req_tready}, (i % 2 == 0) ? 64'd1 : 64'd0);
      checkOutput("rr_wr_ready", {63'd0, wr_req_tready}, (i % 2 == 1) ? 64'd1 : 64'd0);
      cycle();
      if (i % 2 == 0) rd_req_tdata = rd_req_tdata + 43'd1;
      else            wr_req_tdata = wr_req_tdata + 43'd1;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge s_axi_clk);
      checkOutput("full_rd_blocked", {63'd0, rd_req_tready}, 64'd0);
      checkOutput("full_wr_blocked", {63'd0, wr_req_tready}, 64'd0);
      checkOutput("full_outstanding", 64'(outstanding), 64'd4);
      cycle();
    end
    expRd.push_back(33'h0AA);
    xl_rsp_tdata = 33'h0AA; xl_rsp_tvalid = 1'b1;
    @(negedge s_axi_clk);
    checkOutput("full_same_cycle_blocked", {63'd0, rd_req_tready}, 64'd0);
    cycle();
    xl_rsp_tvalid = 1'b0;
    expXl.push_back({1'b0, 43'h102});
    @(negedge s_axi_clk);
    checkOutput("full_regrant_rd", {63'd0, rd_req_tready}, 64'd1);
    checkOutput("full_regrant_wr", {63'd0, wr_req_tready}, 64'd0);
    cycle();
    rd_req_tvalid = 1'b0; wr_req_tvalid = 1'b0;
    checkOutput("full_outstanding_again", 64'(outstanding), 64'd4);
    sendRsp(33'h0B1, 1'b1);
    sendRsp(33'h0B2, 1'b0);
    sendRsp(33'h0B3, 1'b1);
    sendRsp(33'h0B4, 1'b0);
    checkOutput("full_drained", 64'(outstanding), 64'd0);

    // In-order routing R,W,W,R with a write-side stall.
    applyStimulus(1'b0, 43'h301);
    applyStimulus(1'b1, 43'h302);
    applyStimulus(1'b1, 43'h303);
    applyStimulus(1'b0, 43'h304);
    cycle();
    checkOutput("order_outstanding", 64'(outstanding), 64'd4);
    sendRsp(33'h00A, 1'b0);
    wr_rsp_tready = 1'b0;
    expWr.push_back(33'h00B);
    xl_rsp_tdata = 33'h00B; xl_rsp_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge s_axi_clk);
      checkOutput("stall_xl_rsp_tready", {63'd0, xl_rsp_tready}, 64'd0);
      checkOutput("stall_wr_rsp_tvalid", {63'd0, wr_rsp_tvalid}, 64'd1);
      checkOutput("stall_rd_rsp_tvalid", {63'd0, rd_rsp_tvalid}, 64'd0);
      cycle();
    end
    wr_rsp_tready = 1'b1;
    @(negedge s_axi_clk);
    checkOutput("stall_release", {63'd0, xl_rsp_tready}, 64'd1);
    cycle();
    xl_rsp_tvalid = 1'b0;
    checkOutput("order_outstanding_2", 64'(outstanding), 64'd2);
    sendRsp(33'h00C, 1'b1);
    sendRsp(33'h00D, 1'b0);
    checkOutput("order_drained", 64'(outstanding), 64'd0);

    // Orphan response: sunk, flag set and sticky.
    rd_rsp_tready = 1'b0; wr_rsp_tready = 1'b0;
    xl_rsp_tdata = 33'h1FF; xl_rsp_tvalid = 1'b1;
    @(negedge s_axi_clk);
    checkOutput("orphan_xl_rsp_tready", {63'd0, xl_rsp_tready}, 64'd1);
    checkOutput("orphan_rd_rsp_tvalid", {63'd0, rd_rsp_tvalid}, 64'd0);
    checkOutput("orphan_wr_rsp_tvalid", {63'd0, wr_rsp_tvalid}, 64'd0);
    cycle();
    xl_rsp_tvalid = 1'b0;
    checkOutput("orphan_set", {63'd0, orphan_err}, 64'd1);
    repeat (3) cycle();
    checkOutput("orphan_sticky", {63'd0, orphan_err}, 64'd1);
    checkOutput("orphan_outstanding", 64'(outstanding), 64'd0);
    rd_rsp_tready = 1'b1; wr_rsp_tready = 1'b1;

    // Reset mid-operation: three outstanding with one beat staged.
    applyStimulus(1'b0, 43'h401);
    applyStimulus(1'b1, 43'h402);
    cycle();
    xl_req_tready = 1'b0;
    applyStimulus(1'b0, 43'h403);
    checkOutput("midrst_outstanding", 64'(outstanding), 64'd3);
    checkOutput("midrst_staged", {63'd0, xl_req_tvalid}, 64'd1);
    wr_req_tdata = 43'h404; wr_req_tvalid = 1'b1;
    #2;
    s_aresetn = 1'b0;
    flushQueues();
    #1;
    checkOutput("midrst_xl_req_tvalid", {63'd0, xl_req_tvalid}, 64'd0);
    checkOutput("midrst_wr_req_tready", {63'd0, wr_req_tready}, 64'd0);
    checkOutput("midrst_outstanding_0", 64'(outstanding), 64'd0);
    checkOutput("midrst_orphan_clear", {63'd0, orphan_err}, 64'd0);
    checkOutput("midrst_rd_rsp_tvalid", {63'd0, rd_rsp_tvalid}, 64'd0);
    wr_req_tvalid = 1'b0;
    xl_req_tready = 1'b1;
    cycle();
    cycle();
    s_aresetn = 1'b1;
    xl_rsp_tdata = 33'h0EE; xl_rsp_tvalid = 1'b1;
    cycle();
    xl_rsp_tvalid = 1'b0;
    checkOutput("postrst_orphan", {63'd0, orphan_err}, 64'd1);
    rd_req_tdata = 43'h405; rd_req_tvalid = 1'b1;
    wr_req_tdata = 43'h406; wr_req_tvalid = 1'b1;
    expXl.push_back({1'b0, 43'h405});
    @(negedge s_axi_clk);
    checkOutput("postrst_first_rd", {63'd0, rd_req_tready}, 64'd1);
    checkOutput("postrst_first_wr", {63'd0, wr_req_tready}, 64'd0);
    cycle();
    rd_req_tvalid = 1'b0;
    expXl.push_back({1'b1, 43'h406});
    @(negedge s_axi_clk);
    checkOutput("postrst_second_wr", {63'd0, wr_req_tready}, 64'd1);
    cycle();
    wr_req_tvalid = 1'b0;
    sendRsp(33'h005, 1'b0);
    sendRsp(33'h006, 1'b1);
    cycle();
    checkOutput("end_outstanding", 64'(outstanding), 64'd0);
    checkOutput("end_xl_queue_empty", 64'(expXl.size()), 64'd0);
    checkOutput("end_rd_queue_empty", 64'(expRd.size()), 64'd0);
    checkOutput("end_wr_queue_empty", 64'(expWr.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
